// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Default 640x480@60 timing constants, derived line/frame totals, the
// coordinate type shared by the counters, and a small window-compare helper.
// No ports: imported by vga_axis_counter and vga_sync_gen.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Modulo-MODULUS up-counter for one screen axis. Advances only when en is
// high; wrap flags the enabled step from MODULUS-1 back to 0.
// Ports:
//   clk    in   counting clock
//   rst    in   asynchronous active-high reset, clears count
//   en     in   advance on this clock
//   count  out  current registered position
//   next   out  value count takes on the next rising edge (combinational)
//   wrap   out  en && count == MODULUS-1 (combinational)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int MODULUS = H_TOTAL_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output coord_t next,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    next = count;
    if (en) begin
      next = (count == LAST) ? '0 : count + coord_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; reset sits in the sensitivity list to act asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Free-running VGA raster timing generator. Two axis counters track the
// beam position; all timing strobes are registered from the counters'
// next-state values so they line up with the DrawX/DrawY they describe.
// Ports:
//   vga_clk      in   pixel clock
//   reset        in   asynchronous active-high reset, parks beam at (0,0)
//   DrawX        out  horizontal position 0..H_TOTAL-1
//   DrawY        out  vertical position 0..V_TOTAL-1
//   hs           out  horizontal sync, active-low
//   vs           out  vertical sync, active-low
//   blank        out  1 inside the visible area
//   sync         out  composite sync, constant 0
//   line_start   out  high while DrawX == 0
//   frame_start  out  high while DrawX == 0 and DrawY == 0
//   frame_count  out  completed frames, modulo 256
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_LO  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_LO  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t h_count, h_next;
  coord_t v_count, v_next;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(.MODULUS(H_TOTAL)) u_h_counter (
    .clk   (vga_clk),
    .rst   (reset),
    .en    (1'b1),
    .count (h_count),
    .next  (h_next),
    .wrap  (h_wrap)
  );

  // The vertical axis steps only when the line ends, so its wrap marks the
  // (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition.
  vga_axis_counter #(.MODULUS(V_TOTAL)) u_v_counter (
    .clk   (vga_clk),
    .rst   (reset),
    .en    (h_wrap),
    .count (v_count),
    .next  (v_next),
    .wrap  (v_wrap)
  );

  assign DrawX = h_count;
  assign DrawY = v_count;
  assign sync  = 1'b0;

  // Strobes are decoded from next-state positions and registered, so they
  // change on the same edge as the counters. Reset values match (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      frame_count <= '0;
    end else begin
      hs          <= !in_window(h_next, H_SYNC_LO, H_SYNC_HI);
      vs          <= !in_window(v_next, V_SYNC_LO, V_SYNC_HI);
      blank       <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
      if (v_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Drives two generator instances from one clock and reset: one with the
// default 640x480 timing (line-level checks) and one with a tiny raster so
// whole frames and the frame-counter wrap fit in a short run. A position
// model pushes the expected output word for every edge onto a queue per
// instance; the word is popped and compared once the edge has happened.
module tb_vga_sync_gen;

  localparam int DH_VIS = 640, DH_FP = 16, DH_SW = 96, DH_BP = 48, DH_TOT = 800;
  localparam int DV_VIS = 480, DV_FP = 10, DV_SW = 2,  DV_BP = 33, DV_TOT = 525;

  localparam int SH_VIS = 10, SH_FP = 2, SH_SW = 3, SH_BP = 2, SH_TOT = 17;
  localparam int SV_VIS = 8,  SV_FP = 2, SV_SW = 2, SV_BP = 3, SV_TOT = 15;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic       sync;
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
  logic       s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;

  obs_t d_now, s_now;
  assign d_now = {d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc, d_sync};
  assign s_now = {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc, s_sync};

  obs_t q_d[$];
  obs_t q_s[$];

  int tests = 0;
  int fails = 0;

  int md_x = 0, md_y = 0, md_fc = 0;
  int ms_x = 0, ms_y = 0, ms_fc = 0;

  always #5 vga_clk = ~vga_clk;

  vga_sync_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .hs          (d_hs),
    .vs          (d_vs),
    .blank       (d_blank),
    .sync        (d_sync),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_sync_gen #(
    .H_VISIBLE (SH_VIS), .H_FRONT (SH_FP), .H_SYNC (SH_SW), .H_BACK (SH_BP),
    .V_VISIBLE (SV_VIS), .V_FRONT (SV_FP), .V_SYNC (SV_SW), .V_BACK (SV_BP)
  ) dut_small (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .hs          (s_hs),
    .vs          (s_vs),
    .blank       (s_blank),
    .sync        (s_sync),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Output word the generator must show at raster position (x,y).
  function automatic obs_t expect_at(input int x, input int y, input int fc,
                                     input int hv, input int hf, input int hsw,
                                     input int vv, input int vf, input int vsw);
    obs_t e;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    e.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    e.blank = (x < hv) && (y < vv);
    e.ls    = (x == 0);
    e.fs    = (x == 0) && (y == 0);
    e.fc    = 8'(fc);
    e.sync  = 1'b0;
    return e;
  endfunction

  task automatic advance(inout int x, inout int y, inout int fc, input int ht, input int vt);
    if (x == ht - 1) begin
      x = 0;
      if (y == vt - 1) begin
        y  = 0;
        fc = (fc + 1) % 256;
      end else begin
        y = y + 1;
      end
    end else begin
      x = x + 1;
    end
  endtask

  // One clock edge: predict, push, clock, pop, compare.
  task automatic tick();
    obs_t ed, es;
    if (reset) begin
      md_x = 0; md_y = 0; md_fc = 0;
      ms_x = 0; ms_y = 0; ms_fc = 0;
    end else begin
      advance(md_x, md_y, md_fc, DH_TOT, DV_TOT);
      advance(ms_x, ms_y, ms_fc, SH_TOT, SV_TOT);
    end
    q_d.push_back(expect_at(md_x, md_y, md_fc, DH_VIS, DH_FP, DH_SW, DV_VIS, DV_FP, DV_SW));
    q_s.push_back(expect_at(ms_x, ms_y, ms_fc, SH_VIS, SH_FP, SH_SW, SV_VIS, SV_FP, SV_SW));
    @(posedge vga_clk);
    #1;
    ed = q_d.pop_front();
    es = q_s.pop_front();
    if (fails < 20) begin
      check("cycle_default", 64'(d_now), 64'(ed));
      check("cycle_small", 64'(s_now), 64'(es));
    end
  endtask

  initial begin
    int   ls_cnt, hs_low, hs_first, hs_rise;
    int   fs_cnt, blank_cnt, vs_low, vs_first, vs_last;
    logic b639, b640, b_s_row, b_s_vis;
    obs_t reset_d, reset_s;

    reset_d = expect_at(0, 0, 0, DH_VIS, DH_FP, DH_SW, DV_VIS, DV_FP, DV_SW);
    reset_s = expect_at(0, 0, 0, SH_VIS, SH_FP, SH_SW, SV_VIS, SV_FP, SV_SW);

    // Reset asserted before the first clock edge: values appear without a clock.
    #1 reset = 1'b1;
    #2;
    check("reset_async_default", 64'(d_now), 64'(reset_d));
    check("reset_async_small", 64'(s_now), 64'(reset_s));
    tick();
    tick();
    reset = 1'b0;

    // First line of the default raster.
    check("ls_clock0", 64'(d_ls), 64'(1'b1));
    ls_cnt = 0;
    b639 = 1'bx;
    b640 = 1'bx;
    for (int i = 1; i <= DH_TOT; i++) begin
      tick();
      if (i == 1) begin
        check("first_edge_x", 64'(d_x), 64'(1));
        check("first_edge_ls", 64'(d_ls), 64'(1'b0));
      end
      if (d_ls) ls_cnt++;
      if (d_x == 10'd639 && d_y == 10'd0) b639 = d_blank;
      if (d_x == 10'd640 && d_y == 10'd0) b640 = d_blank;
    end
    check("line_end_x", 64'(d_x), 64'(0));
    check("line_end_y", 64'(d_y), 64'(1));
    check("ls_clock800", 64'(d_ls), 64'(1'b1));
    check("ls_count_line", 64'(ls_cnt), 64'(1));
    check("blank_x639", 64'(b639), 64'(1'b1));
    check("blank_x640", 64'(b640), 64'(1'b0));

    // Second line: hsync window.
    hs_low = 0;
    hs_first = -1;
    hs_rise = -1;
    for (int i = 0; i < DH_TOT; i++) begin
      tick();
      if (!d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
      end else if (hs_first >= 0 && hs_rise < 0) begin
        hs_rise = int'(d_x);
      end
    end
    check("hs_low_clocks", 64'(hs_low), 64'(DH_SW));
    check("hs_first_low_x", 64'(hs_first), 64'(656));
    check("hs_high_again_x", 64'(hs_rise), 64'(752));
    check("line2_end_y", 64'(d_y), 64'(2));

    // Move to mid-frame, then reset between edges.
    repeat (300) tick();
    check("pre_reset_x", 64'(d_x), 64'(300));
    check("pre_reset_small_fc", 64'(s_fc), 64'((2 * DH_TOT + 300) / S_FRAME));
    #2 reset = 1'b1;
    #1;
    check("reset_mid_default", 64'(d_now), 64'(reset_d));
    check("reset_mid_small", 64'(s_now), 64'(reset_s));
    tick();
    tick();
    reset = 1'b0;
    check("fc_after_release_default", 64'(d_fc), 64'(0));
    check("fc_after_release_small", 64'(s_fc), 64'(0));

    // One full small frame: every position exactly once, ending on (0,0).
    fs_cnt = 0; blank_cnt = 0; vs_low = 0; vs_first = -1; vs_last = -1;
    b_s_row = 1'bx;
    b_s_vis = 1'bx;
    for (int i = 0; i < S_FRAME; i++) begin
      tick();
      if (s_fs) fs_cnt++;
      if (s_blank) blank_cnt++;
      if (!s_vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(s_y);
        vs_last = int'(s_y);
      end
      if (s_x == 10'd0 && s_y == 10'(SV_VIS)) b_s_row = s_blank;
      if (s_x == 10'(SH_VIS - 1) && s_y == 10'(SV_VIS - 1)) b_s_vis = s_blank;
    end
    check("frame_end_pos", 64'({s_x, s_y}), 64'(20'd0));
    check("frame_start_pulse", 64'(s_fs), 64'(1'b1));
    check("frame_start_count", 64'(fs_cnt), 64'(1));
    check("frame_count_one", 64'(s_fc), 64'(1));
    check("blank_count", 64'(blank_cnt), 64'(SH_VIS * SV_VIS));
    check("blank_row_vvisible", 64'(b_s_row), 64'(1'b0));
    check("blank_last_visible", 64'(b_s_vis), 64'(1'b1));
    check("vs_low_clocks", 64'(vs_low), 64'(SV_SW * SH_TOT));
    check("vs_first_line", 64'(vs_first), 64'(SV_VIS + SV_FP));
    check("vs_last_line", 64'(vs_last), 64'(SV_VIS + SV_FP + SV_SW - 1));

    // Frames 2..255, then the 256th transition wraps the counter.
    repeat (254 * S_FRAME) tick();
    check("frame_count_255", 64'(s_fc), 64'(255));
    repeat (S_FRAME - 1) tick();
    check("before_wrap_fc", 64'(s_fc), 64'(255));
    check("before_wrap_pos", 64'({s_x, s_y}), 64'({10'(SH_TOT - 1), 10'(SV_TOT - 1)}));
    tick();
    check("wrap_fc", 64'(s_fc), 64'(0));
    check("wrap_fs", 64'(s_fs), 64'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001: Parameter H_VISIBLE, 640, active pixels per line.
REQ-002: Parameter H_FRONT, 16, horizontal front porch in clocks.
REQ-003: Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004: Parameter H_BACK, 48, horizontal back porch in clocks; H_TOTAL = sum = 800.
REQ-005: Parameter V_VISIBLE, 480, active lines per frame.
REQ-006: Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007: Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008: Parameter V_BACK, 33, vertical back porch in lines; V_TOTAL = sum = 525.
REQ-009: vga_clk  input  1  pixel clock; all state on its rising edge.
REQ-010: reset  input  1  asynchronous, active-high reset.
REQ-011: DrawX  output  10  current horizontal counter value, 0..H_TOTAL-1.
REQ-012: DrawY  output  10  current vertical counter value, 0..V_TOTAL-1.
REQ-013: hs  output  1  horizontal sync, active-low.
REQ-014: vs  output  1  vertical sync, active-low.
REQ-015: blank  output  1  display-enable: 1 inside visible area, 0 otherwise (downstream pixel stages drive colour only when 1).
REQ-016: sync  output  1  composite sync, tied 0.
REQ-017: line_start  output  1  one-cycle pulse while DrawX == 0.
REQ-018: frame_start  output  1  one-cycle pulse while DrawX == 0 and DrawY == 0.
REQ-019: frame_count  output  8  completed-frame counter.

Function
REQ-020: DrawX SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0.
REQ-021: DrawY SHALL increment by 1 only on the clock where DrawX wraps, and wrap from V_TOTAL-1 to 0 when both wrap.
REQ-022: hs SHALL be 0 exactly when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 default), else 1.
REQ-023: vs SHALL be 0 exactly when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 default), else 1.
REQ-024: blank SHALL be 1 exactly when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-025: hs, vs, blank, line_start, frame_start SHALL be registered, computed from next-state counter values, so each is cycle-aligned with the DrawX/DrawY it describes (zero relative latency, no combinational path from counters to outputs).
REQ-026: frame_count SHALL increment by 1 on the clock where DrawX/DrawY transition from (H_TOTAL-1, V_TOTAL-1) to (0,0), wrapping 255 -> 0.
REQ-027: Counter arithmetic SHALL be 10-bit unsigned; comparisons use parameters, no hardcoded values.
REQ-028: No input other than vga_clk/reset exists; the generator free-runs.

Reset
REQ-029: While reset is 1: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, line_start=1, frame_start=1, frame_count=0 (values consistent with position (0,0)).
REQ-030: Reset SHALL take effect asynchronously on assertion; first rising edge after deassertion moves to DrawX=1, DrawY=0, pulses low.
REQ-031: Reset mid-frame SHALL abandon the frame without incrementing frame_count.

Structure
REQ-032: Package vga_timing_pkg SHALL hold the default timing constants and derived H_TOTAL/V_TOTAL.
REQ-033: One sub-module vga_axis_counter (parameterised modulus, wrap output, enable input) SHALL be instantiated twice: horizontal (enable=1) and vertical (enable=horizontal wrap).

Verification
REQ-034: Release reset, run 800 clocks -> DrawX returns to 0, DrawY=1, line_start high exactly at clocks 0 and 800.
REQ-035: Sample hs across one line -> low for exactly 96 clocks, first low at DrawX=656, high again at DrawX=752.
REQ-036: Run one full frame (420000 clocks) -> vs low for exactly 2 lines at DrawY 490-491; frame_start single pulse at (0,0); frame_count=1.
REQ-037: Count blank=1 cycles over one frame -> exactly 307200; blank=0 at DrawX=640,DrawY=0 and DrawX=0,DrawY=480.
REQ-038: Assert reset asynchronously at DrawX=300, DrawY=200 between edges -> outputs immediately reach REQ-029 values; frame_count=0 after release.
REQ-039: Run 256 frames -> frame_count wraps to 0 exactly on the 256th (0,0) transition.
